keypad_scan: RTL and testbench

- Scans a 4x4 matrix keypad and produces debounced key states and single-cycle press pulses.
- It is the stage directly upstream of the buzzer music controller. It drives the keypad rows, samples the columns, and produces key_pulse[15:0].
- key_pulse[0] serves as the play/start enable.
- Every key is debounced independently, so any number of keys can be held at once.

---
 rtl/keypad_scan.sv | 95 +++++++++
 tb/tb_keypad_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, samples the
// synchronized columns once per row period and debounces every key on its own.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [15:0] key_state,
  output logic [15:0] key_pulse
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       col_m_q;
  logic [3:0]       col_s_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [15:0]      key_state_q, key_state_d;
  logic [15:0]      key_pulse_q, key_pulse_d;
  logic             sample;
  logic             raw;

  always_comb begin
    sample      = (div_cnt_q == DIV_LAST);
    div_cnt_d   = sample ? '0 : div_cnt_q + 1'b1;
    row_idx_d   = row_idx_q;
    row_d       = row_q;
    key_state_d = key_state_q;
    raw         = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cnt_d[k] = cnt_q[k];
    end

    if (sample) begin
      row_idx_d = row_idx_q + 2'd1;
      row_d     = ~(4'b0001 << row_idx_d);
      // Only the four keys of the row currently driven low are evaluated.
      for (int k = 0; k < 16; k++) begin
        if (row_idx_q == 2'(k / 4)) begin
          raw = ~col_s_q[k % 4];
          if (raw == key_state_q[k]) begin
            cnt_d[k] = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            key_state_d[k] = ~key_state_q[k];
            cnt_d[k]       = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
      end
    end

    key_pulse_d = key_state_d & ~key_state_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_m_q     <= 4'b1111;
      col_s_q     <= 4'b1111;
      div_cnt_q   <= '0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      key_state_q <= '0;
      key_pulse_q <= '0;
      for (int k = 0; k < 16; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      col_m_q     <= col;
      col_s_q     <= col_m_q;
      div_cnt_q   <= div_cnt_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      key_state_q <= key_state_d;
      key_pulse_q <= key_pulse_d;
      for (int k = 0; k < 16; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign row       = row_q;
  assign key_state = key_state_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives col from row, and a
// sample-history model predicts row, key_state and key_pulse every cycle.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam logic [7:0] WMASK = 8'((1 << DB) - 1);

  logic        clk;
  logic        rstn;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic [15:0] key_pulse;
  logic [15:0] pressed;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .col       (col),
    .row       (row),
    .key_state (key_state),
    .key_pulse (key_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4+c]) col[c] = 1'b0;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each key keeps a history of its own samples; it flips once the last
  // DB samples taken since its previous flip all disagree with its state.
  logic [15:0] m_state, m_pulse, ph1, ph2;
  logic [3:0]  m_row;
  logic [7:0]  hist [16];
  int          since [16];
  int          edges;

  task automatic model_reset();
    m_state = '0; m_pulse = '0; m_row = 4'b1110;
    ph1 = '0; ph2 = '0; edges = 0;
    for (int k = 0; k < 16; k++) begin
      hist[k] = '0; since[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [15:0] seen;
    int          r, k;
    logic        smp;
    seen = ph2; ph2 = ph1; ph1 = pressed;
    m_pulse = '0;
    if (edges % SD == SD - 1) begin
      r = (edges / SD) % 4;
      for (int c = 0; c < 4; c++) begin
        k   = r * 4 + c;
        smp = seen[k];
        hist[k]  = {hist[k][6:0], smp};
        since[k] = since[k] + 1;
        if (since[k] >= DB && (hist[k] & WMASK) == (m_state[k] ? 8'h00 : WMASK)) begin
          m_state[k] = ~m_state[k];
          since[k]   = 0;
          if (m_state[k]) m_pulse[k] = 1'b1;
        end
      end
    end
    edges = edges + 1;
    m_row = ~(4'b0001 << ((edges / SD) % 4));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  int pulse_cnt [16];
  int last_edge [16];

  task automatic clear_pulses();
    for (int k = 0; k < 16; k++) begin
      pulse_cnt[k] = 0; last_edge[k] = -1;
    end
  endtask

  initial begin
    clear_pulses();
    forever begin
      @(negedge clk);
      chk("row", 32'(row), 32'(m_row));
      chk("key_state", 32'(key_state), 32'(m_state));
      chk("key_pulse", 32'(key_pulse), 32'(m_pulse));
      for (int k = 0; k < 16; k++) begin
        if (key_pulse[k]) begin
          pulse_cnt[k] = pulse_cnt[k] + 1;
          last_edge[k] = edges;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input logic [15:0] keys);
    rstn = 1'b0;
    pressed = keys;
    tick(2);
    rstn = 1'b1;
    clear_pulses();
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int k = 0; k < 16; k++) s += pulse_cnt[k];
    return s;
  endfunction

  initial begin
    rstn = 1'b0;
    pressed = '0;
    tick(1);
    chk("reset_row", 32'(row), 32'h0000000E);
    chk("reset_state", 32'(key_state), 32'h0);

    // Idle scan: row walks 1110,1101,1011,0111 with four cycles per row.
    do_reset(16'h0000);
    tick(3);  chk("row_e3", 32'(row), 32'hE);
    tick(1);  chk("row_e4", 32'(row), 32'hD);
    tick(4);  chk("row_e8", 32'(row), 32'hB);
    tick(4);  chk("row_e12", 32'(row), 32'h7);
    tick(4);  chk("row_e16", 32'(row), 32'hE);
    tick(32);
    chk("idle_pulses", 32'(total_pulses()), 32'd0);

    // Key 6 held from reset release: row-1 samples at edges 7,23,39.
    do_reset(16'h0040);
    tick(160);
    chk("k6_pulse_cnt", 32'(pulse_cnt[6]), 32'd1);
    chk("k6_pulse_edge", 32'(last_edge[6]), 32'd40);
    chk("k6_only_pulse", 32'(total_pulses()), 32'd1);
    chk("k6_state", 32'(key_state), 32'h0040);

    // Release: falls at edge 199, no pulse.
    pressed = '0; clear_pulses();
    tick(64);
    chk("k6_release_state", 32'(key_state), 32'h0);
    chk("k6_release_pulse", 32'(total_pulses()), 32'd0);

    // Bounce: 2 scans down, 1 up, 2 down, 1 up, then a real 4-scan hold.
    pressed = 16'h0040; tick(32);
    pressed = '0;       tick(16);
    pressed = 16'h0040; tick(32);
    chk("bounce_state", 32'(key_state), 32'h0);
    chk("bounce_pulse", 32'(total_pulses()), 32'd0);
    pressed = '0;       tick(16);
    pressed = 16'h0040; tick(64);
    chk("bounce_hold_cnt", 32'(pulse_cnt[6]), 32'd1);
    chk("bounce_hold_edge", 32'(last_edge[6]), 32'd360);
    pressed = '0; tick(64);

    // Keys 0,3 (row 0) and 12 (row 3) held together from edge 448.
    pressed = 16'h1009; clear_pulses();
    tick(64);
    chk("k0_edge", 32'(last_edge[0]), 32'd484);
    chk("k3_edge", 32'(last_edge[3]), 32'd484);
    chk("k12_edge", 32'(last_edge[12]), 32'd496);
    chk("multi_pulses", 32'(total_pulses()), 32'd3);
    chk("multi_state", 32'(key_state), 32'h1009);
    pressed = '0; tick(64);

    // Async reset with key 6 at count 2 and key 0 pulsing this very cycle.
    pressed = 16'h0041; clear_pulses();
    tick(36);
    chk("pre_rst_pulse", 32'(key_pulse), 32'h0001);
    chk("pre_rst_row", 32'(row), 32'hD);
    rstn = 1'b0;
    #1;
    chk("async_row", 32'(row), 32'hE);
    chk("async_state", 32'(key_state), 32'h0);
    chk("async_pulse", 32'(key_pulse), 32'h0);
    tick(2);
    rstn = 1'b1;
    clear_pulses();
    tick(64);
    chk("post_rst_k6_edge", 32'(last_edge[6]), 32'd40);
    chk("post_rst_k0_edge", 32'(last_edge[0]), 32'd36);
    chk("post_rst_pulses", 32'(total_pulses()), 32'd2);
    chk("post_rst_state", 32'(key_state), 32'h0041);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
